// File: rtl/mux_pkg.sv
// Shared definitions for the dual-lane TDM mux/demux pair: state encoding,
// last slot index and default lane width.
package mux_pkg;

  localparam int         W_DEF     = 4;
  localparam logic [1:0] SLOT_LAST = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// 2-bit TDM slot index: clear, load-to-1 (frame start consumed slot 0),
// increment with natural 3->0 wrap. Shared with the transmit-side sequencer.
module tdm_slot_counter (
  input  logic       clk,
  input  logic       clr,
  input  logic       load1,
  input  logic       inc,
  output logic [1:0] sel
);

  // clear wins over load, load wins over increment
  always_ff @(posedge clk) begin
    if (clr)        sel <= 2'd0;
    else if (load1) sel <= 2'd1;
    else if (inc)   sel <= sel + 2'd1;
  end

endmodule

// File: rtl/demux_4_1_dual_seq.sv
// Dual-lane 4:1 TDM demux. Slots 0..3 of each lane collect in a shadow bank;
// a completed frame is copied atomically into the registered output bank.
// Optional: DEMUX_SYNC_CHECK_EN enables the sync_err pulse (mid-frame sync,
// or word dropped while waiting for sync). Without it sync_err is 0.
import mux_pkg::*;

module demux_4_1_dual_seq #(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_sync,
  input  logic [W-1:0] in0123,
  input  logic [W-1:0] inABCD,
  output logic         in_ready,
  input  logic         out_hold,
  output logic [1:0]   sel,
  output logic [W-1:0] out0,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2,
  output logic [W-1:0] out3,
  output logic [W-1:0] outA,
  output logic [W-1:0] outB,
  output logic [W-1:0] outC,
  output logic [W-1:0] outD,
  output logic         frame_valid,
  output logic         sync_err
);

  // [lane][slot][bit]; lane 0 = 0123, lane 1 = ABCD
  logic [1:0][3:0][W-1:0] shadow, shadow_nxt, obank;

  state_t     state, state_nxt;
  logic       acc;
  logic       ld1, inc, wr_en, copy, err, err_en;
  logic [1:0] wr_slot;
  logic       fv_q, serr_q;

  assign in_ready = (state != PEND);
  assign acc      = in_valid & in_ready;

  tdm_slot_counter u_cnt (
    .clk   (clk),
    .clr   (rst),
    .load1 (ld1),
    .inc   (inc),
    .sel   (sel)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state, slot write control, copy and error strobes
  always_comb begin
    state_nxt = state;
    ld1       = 1'b0;
    inc       = 1'b0;
    wr_en     = 1'b0;
    wr_slot   = sel;
    copy      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          if (in_sync) begin
            ld1       = 1'b1;
            wr_en     = 1'b1;
            wr_slot   = 2'd0;
            state_nxt = RUN;
          end else begin
            err = 1'b1;  // word dropped while unaligned
          end
        end
      end
      RUN: begin
        if (acc) begin
          if (in_sync && sel != 2'd0) begin
            // realign: partial frame is abandoned, this word restarts at slot 0
            ld1     = 1'b1;
            wr_en   = 1'b1;
            wr_slot = 2'd0;
            err     = 1'b1;
          end else begin
            wr_en = 1'b1;
            inc   = 1'b1;  // 3 wraps to 0
            if (sel == SLOT_LAST) begin
              if (out_hold) state_nxt = PEND;
              else          copy      = 1'b1;
            end
          end
        end
      end
      PEND: begin
        if (!out_hold) begin
          copy      = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // shadow with this cycle's word merged in, so slot 3 can go straight to out*
  always_comb begin
    shadow_nxt = shadow;
    if (wr_en) begin
      shadow_nxt[0][wr_slot] = in0123;
      shadow_nxt[1][wr_slot] = inABCD;
    end
  end

`ifdef DEMUX_SYNC_CHECK_EN
  assign err_en = err;
`else
  assign err_en = 1'b0 & err;
`endif

  // shadow bank, output bank and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      obank  <= '0;
      fv_q   <= 1'b0;
      serr_q <= 1'b0;
    end else begin
      shadow <= shadow_nxt;
      if (copy) obank <= shadow_nxt;
      fv_q   <= copy;
      serr_q <= err_en;
    end
  end

  assign out0        = obank[0][0];
  assign out1        = obank[0][1];
  assign out2        = obank[0][2];
  assign out3        = obank[0][3];
  assign outA        = obank[1][0];
  assign outB        = obank[1][1];
  assign outC        = obank[1][2];
  assign outD        = obank[1][3];
  assign frame_valid = fv_q;
  assign sync_err    = serr_q;

endmodule

// File: tb/tb_demux_4_1_dual_seq.sv
// Directed bench for demux_4_1_dual_seq. Inputs change 1 time unit after a
// rising edge; outputs are sampled at the same point after the next edge.
module tb_demux_4_1_dual_seq;

  localparam int W = 4;
`ifdef DEMUX_SYNC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_sync = 1'b0, out_hold = 1'b0;
  logic [W-1:0] in0123 = '0, inABCD = '0;
  logic         in_ready, frame_valid, sync_err;
  logic [1:0]   sel;
  logic [W-1:0] out0, out1, out2, out3, outA, outB, outC, outD;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  demux_4_1_dual_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync),
    .in0123(in0123), .inABCD(inABCD), .in_ready(in_ready), .out_hold(out_hold),
    .sel(sel), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .outA(outA), .outB(outB), .outC(outC), .outD(outD),
    .frame_valid(frame_valid), .sync_err(sync_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1; in_sync = s; in0123 = a; inABCD = b;
    step();
    in_valid = 1'b0; in_sync = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_sync = 1'b0; out_hold = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({out0,out1,out2,out3,outA,outB,outC,outD} !== 32'h0) begin
      n_fail++; $display("FAIL reset_out got %h exp 0", {out0,out1,out2,out3,outA,outB,outC,outD});
    end
    n_chk++;
    if ({sel,frame_valid,sync_err,in_ready} !== 5'b00001) begin
      n_fail++; $display("FAIL reset_ctl got %b exp 00001", {sel,frame_valid,sync_err,in_ready});
    end
  endtask

  task automatic test_basic_frame();
    send(1'b1, 4'h1, 4'h8);
    n_chk++;
    if (sel !== 2'd1) begin n_fail++; $display("FAIL t1_sel1 got %0d exp 1", sel); end
    send(1'b0, 4'h2, 4'h9);
    send(1'b0, 4'h3, 4'hA);
    n_chk++;
    if ({frame_valid, out0} !== 5'h00) begin
      n_fail++; $display("FAIL t1_early got %h exp 00", {frame_valid, out0});
    end
    send(1'b0, 4'h4, 4'hB);
    n_chk++;
    if ({out0,out1,out2,out3,outA,outB,outC,outD} !== 32'h1234_89AB) begin
      n_fail++; $display("FAIL t1_out got %h exp 123489ab", {out0,out1,out2,out3,outA,outB,outC,outD});
    end
    n_chk++;
    if ({frame_valid, sel} !== 3'b100) begin
      n_fail++; $display("FAIL t1_fv got %b exp 100", {frame_valid, sel});
    end
    step();
    n_chk++;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL t1_fv_drop got %b exp 0", frame_valid); end
  endtask

  task automatic test_drop_no_sync();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      send(1'b0, 4'h5 + 4'(i), 4'h5);
      n_chk++;
      if ({sel, sync_err} !== {2'd0, CHK}) begin
        n_fail++; $display("FAIL t2_drop%0d got %b exp %b", i, {sel, sync_err}, {2'd0, CHK});
      end
    end
    step();
    n_chk++;
    if ({out0,out1,out2,out3,frame_valid,sync_err} !== 18'h0) begin
      n_fail++; $display("FAIL t2_out got %h exp 0", {out0,out1,out2,out3,frame_valid,sync_err});
    end
  endtask

  task automatic test_resync();
    logic [3:0] d [6];
    int fv_cnt;
    d = '{4'h1, 4'h2, 4'h7, 4'h8, 4'h9, 4'hA};
    fv_cnt = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(i == 0 || i == 2, d[i], ~d[i]);
      if (frame_valid === 1'b1) fv_cnt++;
      if (i == 2) begin
        n_chk++;
        if ({sync_err, sel} !== {CHK, 2'd1}) begin
          n_fail++; $display("FAIL t3_serr got %b exp %b", {sync_err, sel}, {CHK, 2'd1});
        end
      end
    end
    n_chk++;
    if ({out0,out1,out2,out3,outA,outB,outC,outD} !== 32'h789A_8765) begin
      n_fail++; $display("FAIL t3_out got %h exp 789a8765", {out0,out1,out2,out3,outA,outB,outC,outD});
    end
    step();
    if (frame_valid === 1'b1) fv_cnt++;
    n_chk++;
    if (fv_cnt !== 1) begin n_fail++; $display("FAIL t3_fvcnt got %0d exp 1", fv_cnt); end
  endtask

  task automatic test_hold();
    // bank holds 7,8,9,A / 8,7,6,5 from the previous test
    send(1'b1, 4'h1, 4'h8);
    send(1'b0, 4'h2, 4'h9);
    send(1'b0, 4'h3, 4'hA);
    out_hold = 1'b1;
    send(1'b0, 4'h4, 4'hB);
    in_valid = 1'b1; in_sync = 1'b1; in0123 = 4'hF; inABCD = 4'hF;  // must be ignored
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({in_ready, frame_valid, out0, out1, out2, out3, outA} !== 22'h0_789A8 >> 0) begin
        n_fail++; $display("FAIL t4_hold%0d got %h exp %h", i, {in_ready, frame_valid, out0, out1, out2, out3, outA}, 22'h789A8);
      end
      if (i < 2) step();
    end
    in_valid = 1'b0; in_sync = 1'b0; out_hold = 1'b0;
    step();
    n_chk++;
    if ({out0,out1,out2,out3,outA,outB,outC,outD} !== 32'h1234_89AB) begin
      n_fail++; $display("FAIL t4_out got %h exp 123489ab", {out0,out1,out2,out3,outA,outB,outC,outD});
    end
    n_chk++;
    if ({frame_valid, in_ready, sel} !== 4'b1100) begin
      n_fail++; $display("FAIL t4_rel got %b exp 1100", {frame_valid, in_ready, sel});
    end
  endtask

  task automatic test_back_to_back();
    int fv_cnt;
    fv_cnt = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(i == 0, (i < 4) ? 4'(i + 1) : 4'(i + 7), 4'(i));
      if (frame_valid === 1'b1) fv_cnt++;
      if (i == 4) begin
        n_chk++;
        if ({out0,out1,out2,out3} !== 16'h1234) begin
          n_fail++; $display("FAIL t5_first got %h exp 1234", {out0,out1,out2,out3});
        end
      end
    end
    n_chk++;
    if ({out0,out1,out2,out3,outA,outB,outC,outD} !== 32'hBCDE_4567) begin
      n_fail++; $display("FAIL t5_out got %h exp bcde4567", {out0,out1,out2,out3,outA,outB,outC,outD});
    end
    n_chk++;
    if (fv_cnt !== 2) begin n_fail++; $display("FAIL t5_fvcnt got %0d exp 2", fv_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(1'b1, 4'h1, 4'h1);
    send(1'b0, 4'h2, 4'h2);
    n_chk++;
    if (sel !== 2'd2) begin n_fail++; $display("FAIL t6_sel2 got %0d exp 2", sel); end
    rst = 1'b1; step(); rst = 1'b0;
    n_chk++;
    if ({sel, frame_valid, out0, out1} !== 11'h0) begin
      n_fail++; $display("FAIL t6_rst_run got %h exp 0", {sel, frame_valid, out0, out1});
    end
    send(1'b0, 4'h3, 4'h3);  // IDLE again: dropped
    n_chk++;
    if (sel !== 2'd0) begin n_fail++; $display("FAIL t6_idle got %0d exp 0", sel); end
    send(1'b1, 4'h1, 4'h1);
    send(1'b0, 4'h2, 4'h2);
    send(1'b0, 4'h3, 4'h3);
    out_hold = 1'b1;
    send(1'b0, 4'h4, 4'h4);
    n_chk++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL t6_pend got %b exp 0", in_ready); end
    rst = 1'b1; step(); rst = 1'b0; out_hold = 1'b0;
    n_chk++;
    if ({in_ready, sel, frame_valid, out0, out3, outD} !== 16'h8000) begin
      n_fail++; $display("FAIL t6_rst_pend got %h exp 8000", {in_ready, sel, frame_valid, out0, out3, outD});
    end
    step();
    n_chk++;
    if ({frame_valid, out0, out3} !== 9'h0) begin
      n_fail++; $display("FAIL t6_after got %h exp 0", {frame_valid, out0, out3});
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_drop_no_sync();
    test_resync();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
